// File: rtl/angle_spi_pkg.sv
// Shared types and constants for the angle-sensor SPI responder.
// The parity helper returns the bit that makes a word even parity.
package angle_spi_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int          FRAME_BITS       = 16;
  localparam logic [13:0] DEF_ANGLE_ADDR   = 14'h3FFF;
  localparam logic [13:0] DEF_MAG_ADDR     = 14'h3FFD;
  localparam logic [13:0] DEF_CLR_ERR_ADDR = 14'h0001;

  // Returns 1 when the word has an odd number of ones.
  function automatic logic even_parity16(input logic [15:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Multi-stage synchronizer for one asynchronous SPI pin.
// A final history register provides single-cycle rise/fall strobes.
module spi_input_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;

  // Resetting to 0 means a select held low through reset never looks like a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= (sync_reg << 1) | STAGES'(din);
      prev_reg <= sync_reg[STAGES-1];
    end
  end

  assign level = sync_reg[STAGES-1];
  assign rise  = level & ~prev_reg;
  assign fall  = ~level & prev_reg;

endmodule

// File: rtl/angle_sensor_spi_slave.sv
// SPI mode-1 responder emulating a 14-bit magnetic angle sensor.
// A command received in one frame is answered during the next frame.
module angle_sensor_spi_slave
  import angle_spi_pkg::*;
#(
  parameter int          SYNC_STAGES  = 2,
  parameter logic [13:0] ANGLE_ADDR   = DEF_ANGLE_ADDR,
  parameter logic [13:0] MAG_ADDR     = DEF_MAG_ADDR,
  parameter logic [13:0] CLR_ERR_ADDR = DEF_CLR_ERR_ADDR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sck_i,
  input  logic        ss_n_i,
  input  logic        mosi_i,
  output logic        miso_o,
  input  logic [13:0] angle_i,
  input  logic [13:0] magnitude_i,
  output logic [15:0] cmd_o,
  output logic        frame_done_o,
  output logic        error_o,
  output logic [2:0]  err_flags_o
);

  logic [2:0] raw_in, sync_level, sync_rise, sync_fall;
  assign raw_in = {mosi_i, ss_n_i, sck_i};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      spi_input_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (raw_in[gi]),
        .level   (sync_level[gi]),
        .rise    (sync_rise[gi]),
        .fall    (sync_fall[gi])
      );
    end
  endgenerate

  logic sck_rise, sck_fall, ss_rise, ss_fall, mosi_bit, unused_sync;
  assign sck_rise    = sync_rise[0];
  assign sck_fall    = sync_fall[0];
  assign ss_rise     = sync_rise[1];
  assign ss_fall     = sync_fall[1];
  assign mosi_bit    = sync_level[2];
  assign unused_sync = ^{sync_level[1:0], sync_rise[2], sync_fall[2]};

  state_t                  state_reg;
  logic [FRAME_BITS-1:0]   tx_shift_reg, rx_shift_reg, resp_reg;
  logic [4:0]              bit_cnt_reg;
  logic [2:0]              err_flags_reg;

  logic [2:0]  dec_flags, err_after;
  logic [13:0] dec_data;
  logic        dec_clr, resp_e;
  logic [15:0] resp_next;

  // E reports the flags including anything this frame raises, but before a clear.
  always_comb begin
    dec_flags = 3'b000;
    dec_data  = 14'h0000;
    dec_clr   = 1'b0;
    if (even_parity16(rx_shift_reg)) begin
      dec_flags = 3'b100;
    end else if (!rx_shift_reg[14]) begin
      dec_flags = 3'b010;
    end else if (rx_shift_reg[13:0] == ANGLE_ADDR) begin
      dec_data = angle_i;
    end else if (rx_shift_reg[13:0] == MAG_ADDR) begin
      dec_data = magnitude_i;
    end else if (rx_shift_reg[13:0] == CLR_ERR_ADDR) begin
      dec_data = {11'b0, err_flags_reg};
      dec_clr  = 1'b1;
    end else begin
      dec_flags = 3'b010;
    end
    err_after = err_flags_reg | dec_flags;
    resp_e    = |err_after;
    resp_next = {even_parity16({1'b0, resp_e, dec_data}), resp_e, dec_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      tx_shift_reg  <= '0;
      rx_shift_reg  <= '0;
      resp_reg      <= '0;
      bit_cnt_reg   <= '0;
      err_flags_reg <= '0;
      miso_o        <= 1'b0;
      cmd_o         <= '0;
      frame_done_o  <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      case (state_reg)
        IDLE: begin
          miso_o <= 1'b0;
          if (ss_fall) begin
            tx_shift_reg <= resp_reg;
            bit_cnt_reg  <= '0;
            state_reg    <= SHIFT;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            miso_o    <= 1'b0;
            state_reg <= DONE;
          end else begin
            if (sck_rise) begin
              miso_o       <= tx_shift_reg[FRAME_BITS-1];
              tx_shift_reg <= {tx_shift_reg[FRAME_BITS-2:0], 1'b0};
            end
            if (sck_fall) begin
              rx_shift_reg <= {rx_shift_reg[FRAME_BITS-2:0], mosi_bit};
              if (bit_cnt_reg != 5'(FRAME_BITS + 1))
                bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          if (bit_cnt_reg != 5'(FRAME_BITS)) begin
            err_flags_reg <= err_flags_reg | 3'b001;
          end else begin
            cmd_o         <= rx_shift_reg;
            frame_done_o  <= 1'b1;
            resp_reg      <= resp_next;
            err_flags_reg <= dec_clr ? 3'b000 : err_after;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign err_flags_o = err_flags_reg;
  assign error_o     = |err_flags_reg;

endmodule

// File: tb/tb_angle_sensor_spi_slave.sv
// Self-checking bench: directed table, corner-case sequences and random frames
// compared against a frame-level model of the sensor protocol.
module tb_angle_sensor_spi_slave;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sck_i, ss_n_i, mosi_i;
  logic        miso_o;
  logic [13:0] angle_i, magnitude_i;
  logic [15:0] cmd_o;
  logic        frame_done_o, error_o;
  logic [2:0]  err_flags_o;

  angle_sensor_spi_slave #(.SYNC_STAGES(SYNC)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sck_i        (sck_i),
    .ss_n_i       (ss_n_i),
    .mosi_i       (mosi_i),
    .miso_o       (miso_o),
    .angle_i      (angle_i),
    .magnitude_i  (magnitude_i),
    .cmd_o        (cmd_o),
    .frame_done_o (frame_done_o),
    .error_o      (error_o),
    .err_flags_o  (err_flags_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Frame-level model state: pending reply, sticky flags, last full command.
  logic [15:0] m_resp;
  logic [2:0]  m_flags;
  logic [15:0] m_cmd;

  typedef struct {
    logic [15:0] cmd;
    logic [13:0] ang;
    logic [13:0] mag;
    logic [15:0] exp_resp;
    logic        exp_err;
    logic [2:0]  exp_flags;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    m_resp  = 16'h0000;
    m_flags = 3'b000;
    m_cmd   = 16'h0000;
  endtask

  task automatic model_frame(input logic [15:0] cmd, input int nbits,
                             input logic [13:0] ang, input logic [13:0] mag);
    logic [2:0]  nf;
    logic [13:0] data;
    logic        clr, e, p;
    if (nbits != 16) begin
      m_flags[0] = 1'b1;
    end else begin
      m_cmd = cmd;
      nf = 3'b000; data = 14'h0; clr = 1'b0;
      if (($countones(cmd) % 2) != 0)       nf = 3'b100;
      else if (cmd[14] == 1'b0)             nf = 3'b010;
      else if (cmd[13:0] == 14'h3FFF)       data = ang;
      else if (cmd[13:0] == 14'h3FFD)       data = mag;
      else if (cmd[13:0] == 14'h0001) begin data = {11'b0, m_flags}; clr = 1'b1; end
      else                                  nf = 3'b010;
      e = ((m_flags | nf) != 3'b000);
      p = (($countones({e, data}) % 2) != 0);
      m_resp  = {p, e, data};
      m_flags = clr ? 3'b000 : (m_flags | nf);
    end
  endtask

  task automatic run_frame(input logic [15:0] cmd, input int nbits,
                           input logic [13:0] ang, input logic [13:0] mag,
                           output logic [15:0] got);
    logic [31:0] cap, exp_cap;
    int first_done, n_done;
    angle_i = ang;
    magnitude_i = mag;
    exp_cap = (nbits <= 16) ? (32'(m_resp) >> (16 - nbits)) : (32'(m_resp) << (nbits - 16));
    cap = 32'h0;
    @(negedge clk);
    ss_n_i = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sck_i  = 1'b1;
      mosi_i = (i < 16) ? cmd[15 - i] : 1'b1;
      repeat (5) @(negedge clk);
      cap = (cap << 1) | 32'(miso_o);
      sck_i = 1'b0;
      repeat (5) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    ss_n_i = 1'b1;
    first_done = 0;
    n_done = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (frame_done_o) begin
        n_done++;
        if (first_done == 0) first_done = k;
      end
    end
    model_frame(cmd, nbits, ang, mag);
    check("miso_word", cap, exp_cap);
    check("done_count", 32'(n_done), (nbits == 16) ? 32'd1 : 32'd0);
    if (nbits == 16) check("done_latency", 32'(first_done), 32'(SYNC + 2));
    check("cmd_o", 32'(cmd_o), 32'(m_cmd));
    check("err_flags", 32'(err_flags_o), 32'(m_flags));
    check("error_o", 32'(error_o), 32'(m_flags != 3'b000));
    check("miso_idle", 32'(miso_o), 32'd0);
    got = cap[15:0];
    $display("frame cmd=%h bits=%0d miso=%h flags=%b", cmd, nbits, got, err_flags_o);
  endtask

  initial begin
    logic [15:0] got, cmd;
    logic [14:0] body;
    int kind, nbits, ones, dones;

    vecs[0]  = '{16'hFFFF, 14'h1234, 14'h0ABC, 16'h0000, 1'b0, 3'b000};
    vecs[1]  = '{16'hFFFF, 14'h1234, 14'h0ABC, 16'h9234, 1'b0, 3'b000};
    vecs[2]  = '{16'h7FFD, 14'h1234, 14'h0ABC, 16'h9234, 1'b0, 3'b000};
    vecs[3]  = '{16'hFFFF, 14'h1234, 14'h0ABC, 16'h8ABC, 1'b0, 3'b000};
    vecs[4]  = '{16'h7FFF, 14'h1234, 14'h0ABC, 16'h9234, 1'b1, 3'b100};
    vecs[5]  = '{16'h4001, 14'h1234, 14'h0ABC, 16'hC000, 1'b0, 3'b000};
    vecs[6]  = '{16'hFFFF, 14'h1234, 14'h0ABC, 16'h4004, 1'b0, 3'b000};
    vecs[7]  = '{16'hFFFF, 14'h1234, 14'h0ABC, 16'h9234, 1'b0, 3'b000};
    vecs[8]  = '{16'h0003, 14'h1234, 14'h0ABC, 16'h9234, 1'b1, 3'b010};
    vecs[9]  = '{16'h4001, 14'h1234, 14'h0ABC, 16'hC000, 1'b0, 3'b000};
    vecs[10] = '{16'hC003, 14'h1234, 14'h0ABC, 16'h4002, 1'b1, 3'b010};
    vecs[11] = '{16'h4001, 14'h1234, 14'h0ABC, 16'hC000, 1'b0, 3'b000};
    vecs[12] = '{16'hFFFF, 14'h1234, 14'h0ABC, 16'h4002, 1'b0, 3'b000};

    reset_n = 1'b0; ss_n_i = 1'b1; sck_i = 1'b0; mosi_i = 1'b0;
    angle_i = 14'h0; magnitude_i = 14'h0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(miso_o), 32'd0);
    check("rst_cmd", 32'(cmd_o), 32'd0);
    check("rst_done", 32'(frame_done_o), 32'd0);
    check("rst_error", 32'(error_o), 32'd0);
    check("rst_flags", 32'(err_flags_o), 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 13; v++) begin
      run_frame(vecs[v].cmd, 16, vecs[v].ang, vecs[v].mag, got);
      check("tbl_resp", 32'(got), 32'(vecs[v].exp_resp));
      check("tbl_error", 32'(error_o), 32'(vecs[v].exp_err));
      check("tbl_flags", 32'(err_flags_o), 32'(vecs[v].exp_flags));
    end

    // Aborted frame: framing flag only, reply and command untouched.
    run_frame(16'hFFFF, 10, 14'h1234, 14'h0ABC, got);
    check("abort_flags", 32'(err_flags_o), 32'h1);
    check("abort_cmd", 32'(cmd_o), 32'hFFFF);
    run_frame(16'hFFFF, 16, 14'h1234, 14'h0ABC, got);
    check("abort_resp_kept", 32'(got), 32'h9234);
    run_frame(16'h4001, 16, 14'h1234, 14'h0ABC, got);

    // Over-long frame: framing flag, no decode.
    run_frame(16'h4001, 17, 14'h1234, 14'h0ABC, got);
    check("long_flags", 32'(err_flags_o), 32'h1);
    run_frame(16'h4001, 16, 14'h1234, 14'h0ABC, got);

    // Reset in the middle of a frame with select held low.
    @(negedge clk);
    ss_n_i = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      sck_i = 1'b1; mosi_i = 1'b1;
      repeat (5) @(negedge clk);
      sck_i = 1'b0;
      repeat (5) @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    check("mid_rst_miso", 32'(miso_o), 32'd0);
    check("mid_rst_cmd", 32'(cmd_o), 32'd0);
    check("mid_rst_flags", 32'(err_flags_o), 32'd0);
    check("mid_rst_error", 32'(error_o), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    ones = 0;
    dones = 0;
    for (int i = 0; i < 16; i++) begin
      sck_i = 1'b1;
      repeat (5) @(negedge clk);
      ones += int'(miso_o);
      dones += int'(frame_done_o);
      sck_i = 1'b0;
      repeat (5) @(negedge clk);
      dones += int'(frame_done_o);
    end
    ss_n_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      dones += int'(frame_done_o);
    end
    check("post_rst_quiet_miso", 32'(ones), 32'd0);
    check("post_rst_no_done", 32'(dones), 32'd0);
    check("post_rst_flags", 32'(err_flags_o), 32'd0);
    run_frame(16'hFFFF, 16, 14'h2AAA, 14'h0155, got);
    check("post_rst_resp", 32'(got), 32'h0000);

    // Random traffic against the model.
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 9);
      nbits = 16;
      case (kind)
        0, 1, 2: body = {1'b1, 14'h3FFF};
        3, 4:    body = {1'b1, 14'h3FFD};
        5:       body = {1'b1, 14'h0001};
        6:       body = {1'b0, 14'($urandom)};
        7:       body = {1'b1, 14'($urandom)};
        default: body = 15'($urandom);
      endcase
      cmd = {1'(($countones(body)) % 2), body};
      if (kind == 8) cmd = 16'($urandom);
      if (kind == 9) nbits = ($urandom_range(0, 1) == 1) ? 17 : 12;
      run_frame(cmd, nbits, 14'($urandom), 14'($urandom), got);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
